// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW_DEF      = 5;
    localparam int unsigned MEM_TIMEOUT_DEF = 16;
    localparam int unsigned TO_W_DEF        = 5;
    localparam int unsigned ZERO_REG        = 0;

    typedef enum logic {
        RUN,
        MEMWAIT
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = 7'b1101011;
    localparam ctrl_t CTRL_STALL  = 7'b0000000;
    localparam ctrl_t CTRL_BRANCH = 7'b1111111;
    localparam ctrl_t CTRL_LDUSE  = 7'b0001111;

endpackage

// File: rtl/pipe_sat_cnt.sv
// 32-bit saturating event counter with async active-low reset.
module pipe_sat_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush control for the five-stage pipeline registers, with memory-wait watchdog.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = REG_AW_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned TO_W        = TO_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              mem_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    ctrl_t           ctrl;
    logic            load_use;
    logic            mem_miss;
    logic            timeout_hit;

    assign load_use = ex_mem_read && (ex_rd != REG_AW'(ZERO_REG)) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));
    assign mem_miss    = mem_req && !mem_ready;
    assign timeout_hit = (wait_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        ctrl = CTRL_RUN;
        case (state)
            RUN: begin
                if (mem_miss) begin
                    ctrl = CTRL_STALL;
                end else if (ex_branch_taken) begin
                    ctrl = CTRL_BRANCH;
                end else if (load_use) begin
                    ctrl = CTRL_LDUSE;
                end
            end
            MEMWAIT: begin
                // Completion and abandon both release the pipe; hazards re-evaluate next cycle.
                if (!mem_ready && !timeout_hit) begin
                    ctrl = CTRL_STALL;
                end
            end
            default: ctrl = CTRL_RUN;
        endcase
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_en    = ctrl.idex_en;
    assign idex_flush = ctrl.idex_flush;
    assign exmem_en   = ctrl.exmem_en;
    assign memwb_en   = ctrl.memwb_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_miss) begin
                        state    <= MEMWAIT;
                        wait_cnt <= TO_W'(1);
                    end
                end
                MEMWAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        mem_err  <= 1'b1;
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (state == RUN) ? (mem_miss || (!ex_branch_taken && load_use))
                                      : (!mem_ready && !timeout_hit);
    assign flush_inc = (state == RUN) && !mem_miss && ex_branch_taken;

    pipe_sat_cnt u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_cnt u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed cases plus randomized traffic vs a reference model.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int MT = 4;

    // Expected control vectors {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    localparam logic [6:0] E_ON     = 7'b1101011;
    localparam logic [6:0] E_OFF    = 7'b0000000;
    localparam logic [6:0] E_BRANCH = 7'b1111111;
    localparam logic [6:0] E_LDUSE  = 7'b0001111;

    logic          clk;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
    logic          mem_req, mem_ready;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic          mem_err;
    logic [6:0]    got_ctrl;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]   stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: "waiting" flag, cycles spent on the current access, sticky error.
    bit      m_wait;
    int      m_wcnt;
    bit      m_err;
    longint  m_stall;
    longint  m_flush;

    pipe_hazard_ctrl #(
        .REG_AW      (AW),
        .MEM_TIMEOUT (MT),
        .TO_W        (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .mem_err         (mem_err)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    assign got_ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                          input bit mr, input int rd, input bit br, input bit mq, input bit mrdy);
        id_rs           = AW'(rs);
        id_rt           = AW'(rt);
        id_uses_rs      = urs;
        id_uses_rt      = urt;
        ex_mem_read     = mr;
        ex_rd           = AW'(rd);
        ex_branch_taken = br;
        mem_req         = mq;
        mem_ready       = mrdy;
    endtask

    function automatic bit hazard();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    endfunction

    // Expected control for this cycle from the rules, plus whether it is a stall / flush cycle.
    task automatic model_eval(output logic [6:0] e, output bit st, output bit fl);
        e = E_ON; st = 0; fl = 0;
        if (!m_wait) begin
            if (mem_req && !mem_ready) begin e = E_OFF; st = 1; end
            else if (ex_branch_taken)  begin e = E_BRANCH; fl = 1; end
            else if (hazard())         begin e = E_LDUSE; st = 1; end
        end else if (!mem_ready && m_wcnt < MT - 1) begin
            e = E_OFF; st = 1;
        end
    endtask

    task automatic model_commit(input bit st, input bit fl);
        if (!m_wait) begin
            if (mem_req && !mem_ready) begin m_wait = 1; m_wcnt = 1; end
        end else if (mem_ready) begin
            m_wait = 0; m_wcnt = 0;
        end else if (m_wcnt == MT - 1) begin
            m_err = 1; m_wait = 0; m_wcnt = 0;
        end else begin
            m_wcnt++;
        end
        if (st && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (fl && m_flush < 64'hFFFF_FFFF) m_flush++;
    endtask

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    // Called in the phase just after a rising edge; leaves the same phase one cycle later.
    task automatic step(input string tag);
        logic [6:0] e;
        bit st, fl;
        @(negedge clk);
        model_eval(e, st, fl);
        check({tag, "/ctrl"}, 32'(got_ctrl), 32'(e));
        check({tag, "/err"}, 32'(mem_err), 32'(m_err));
`ifdef HAZ_PERF_CNT_EN
        check({tag, "/stall_cnt"}, stall_cnt, m_stall[31:0]);
        check({tag, "/flush_cnt"}, flush_cnt, m_flush[31:0]);
`endif
        @(posedge clk);
        model_commit(st, fl);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/ctrl", 32'(got_ctrl), 32'(E_ON));
        check("rst/err", 32'(mem_err), 32'd0);
        set_in(5, 0, 1, 0, 1, 5, 0, 0, 0);
        #1;
        check("rst/ldu_decode", 32'(got_ctrl), 32'(E_LDUSE));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Load-use for one cycle, then the bubble clears it
        set_in(5, 0, 1, 0, 1, 5, 0, 0, 0); step("ldu_rs");
        set_in(5, 0, 1, 0, 0, 0, 0, 0, 0); step("ldu_after");
        set_in(0, 7, 0, 1, 1, 7, 0, 0, 0); step("ldu_rt");
        set_in(0, 0, 1, 0, 1, 0, 0, 0, 0); step("ldu_r0");
        set_in(5, 0, 0, 0, 1, 5, 0, 0, 0); step("ldu_unused");

        // Branch overrides load-use
        set_in(5, 0, 1, 0, 1, 5, 1, 0, 0); step("br_over_ldu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("br_after");

        // Memory wait: three stalled cycles then completion
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) step("mw_stall");
        mem_ready = 1; step("mw_done");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mw_idle");

        // Timeout: abandon on the MT-th cycle, error stays set
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) step("to_wait");
        set_in(3, 0, 1, 0, 1, 3, 0, 0, 0); step("to_ldu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step("to_sticky");

        // Reset in the middle of a wait
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) step("rm_wait");
        mem_req = 0;
        #1;
        check("rm_pre/ctrl", 32'(got_ctrl), 32'(E_OFF));
        reset = 1'b0;
        #1;
        check("rm_async/ctrl", 32'(got_ctrl), 32'(E_ON));
        check("rm_async/err", 32'(mem_err), 32'd0);
        model_reset();
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("rm_release");

`ifdef HAZ_PERF_CNT_EN
        force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
        m_stall = 64'hFFFF_FFFE;
        step("pf_force");
        release dut.u_stall_cnt.count;
        set_in(2, 0, 1, 0, 1, 2, 0, 0, 0);
        repeat (3) step("pf_sat");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("pf_hold");
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control end of the five-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Reads hazard information carried in the ID/EX stage and the data-memory handshake.
- Drives the per-stage enable (stall) and flush (bubble) controls those registers consume.
- Tracks multi-cycle memory waits with a state machine and a timeout watchdog.

Parameters:
- REG_AW, 5, register-specifier width.
- MEM_TIMEOUT, 16, maximum consecutive MEMWAIT cycles before abandon; minimum 2.
- TO_W, 5, wait-counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  REG_AW  source register 1 of the instruction in ID.
- id_rt  in  REG_AW  source register 2 of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in EX is a load (from ID/EX).
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID enable.
- ifid_flush  out  1  zero the IF/ID D input.
- idex_en  out  1  ID/EX enable.
- idex_flush  out  1  zero the ID/EX D input (bubble).
- exmem_en  out  1  EX/MEM enable.
- memwb_en  out  1  MEM/WB enable.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Control outputs are combinational from the registered state plus current inputs, so they act on the same clock edge. State, wait counter and mem_err are registered.
- Reset (reset=0, asynchronous): state=RUN, wait_cnt=0, mem_err=0.
  - While in reset, outputs follow the RUN decode of the inputs.
  - Reset asserted mid-MEMWAIT returns to RUN immediately.
- States: RUN, MEMWAIT.
- Default in RUN: all enables=1, all flushes=0.
- Priority in RUN, highest first:
  1. Memory stall: mem_req=1 and mem_ready=0.
     - All enables=0, flushes=0.
     - Next state MEMWAIT, wait_cnt<=1.
  2. Branch flush: ex_branch_taken=1.
     - pc_en=1, ifid_flush=1, idex_flush=1, other enables=1.
     - Exactly one cycle; overrides load-use, because the ID instruction is discarded.
  3. Load-use stall.
     - Condition: ex_mem_read=1, ex_rd!=0, and ((id_uses_rs and id_rs==ex_rd) or (id_uses_rt and id_rt==ex_rd)).
     - Response: pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1, memwb_en=1.
     - One bubble per hazard; the next cycle the load sits in MEM and the condition clears.
- MEMWAIT:
  - mem_ready=1: all enables=1, flushes=0, next state RUN, wait_cnt<=0. Branch and load-use are not evaluated in this cycle; they re-evaluate next cycle from the held stage contents.
  - mem_ready=0 and wait_cnt==MEM_TIMEOUT-1: mem_err<=1 (sticky), all enables=1 (abandon the access), next state RUN, wait_cnt<=0.
  - Otherwise: all enables=0, wait_cnt increments.
- Register 0 never creates a hazard.
- wait_cnt never exceeds MEM_TIMEOUT-1.
- mem_err clears only on reset.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: adds output ports stall_cnt[31:0] and flush_cnt[31:0], both reset to 0 and saturating at 0xFFFFFFFF.
  - stall_cnt increments on each load-use or MEMWAIT-stall cycle.
  - flush_cnt increments on each branch-flush cycle.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN, MEMWAIT);
  - REG_AW default;
  - ZERO_REG constant;
  - MEM_TIMEOUT default.
- One sub-module, pipe_sat_cnt: 32-bit saturating counter with async active-low reset and increment enable. Instantiated twice, only under HAZ_PERF_CNT_EN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_uses_rs=1, id_rs=5 -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; same with ex_rd=0 -> no stall.
- Branch: ex_branch_taken=1 together with the load-use condition above -> ifid_flush=1, idex_flush=1, pc_en=1, no stall; stall_cnt unchanged and flush_cnt+1 when the macro is defined.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all enables=0 for 3 cycles, all=1 on the 4th, state RUN after; mem_err stays 0.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> enables 0 for 3 cycles, 4th cycle enables=1 and mem_err=1, which stays 1 through later normal traffic.
- Reset mid-MEMWAIT: reset=0 asynchronously during cycle 2 of a wait -> state RUN and mem_err=0 immediately; after release with mem_req=0, all enables=1.
- Perf counters (HAZ_PERF_CNT_EN): force stall_cnt to 0xFFFFFFFE, then 3 stall cycles -> stall_cnt reads 0xFFFFFFFF and holds.
